uart_rx_sipo: RTL

- UART receiver: the serial-in/parallel-out counterpart of the transmit-side PISO shifter.
- Recovers 8N1-style frames from an asynchronous serial line using OVERSAMPLE-x mid-bit sampling.
- Presents each received word on a parallel bus with a one-cycle valid strobe.
- Sits between the board RX pin and the UART_full controller/loopback logic.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/baud_tick_gen.sv | 27 ++
 rtl/uart_rx_sipo.sv | 110 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults, receiver FSM encodings and a clog2 helper
package uart_pkg;
    localparam int DEF_BAUD       = 9600;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running one-cycle tick at BAUD*OVERSAMPLE, cleared only by reset
module baud_tick_gen import uart_pkg::*; #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int N   = (DIV < 1) ? 1 : DIV;
    localparam int W   = (N < 2) ? 1 : clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
            tick <= (cnt == LAST);
        end
    end
endmodule

// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: oversampled 8N1-style UART receiver with parallel output and valid/error strobes
module uart_rx_sipo import uart_pkg::*; #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Serial_In,
    output logic [DATA_BITS-1:0] Parallel_Out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);
    localparam int TW = clog2(OVERSAMPLE);
    localparam int BW = clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] MID_BIT   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t            state, state_n;
    logic                 rx_m, rx_s, tick;
    logic [TW-1:0]        tick_cnt, tick_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, out_n;
    logic                 dv_n, fe_n;

    baud_tick_gen #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk(clk),
        .rst(rst),
        .tick(tick)
    );

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m          <= 1'b1;
            rx_s          <= 1'b1;
            state         <= S_IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            Parallel_Out  <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_m          <= Serial_In;
            rx_s          <= rx_m;
            state         <= state_n;
            tick_cnt      <= tick_cnt_n;
            bit_cnt       <= bit_cnt_n;
            shreg         <= shreg_n;
            Parallel_Out  <= out_n;
            data_valid    <= dv_n;
            framing_error <= fe_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        out_n      = Parallel_Out;
        dv_n       = 1'b0;
        fe_n       = 1'b0;
        case (state)
            S_IDLE: if (!rx_s) begin
                tick_cnt_n = '0;
                state_n    = S_START;
            end
            S_START: if (tick) begin
                tick_cnt_n = tick_cnt + 1'b1;
                if (tick_cnt == MID_START) begin
                    tick_cnt_n = '0;
                    bit_cnt_n  = '0;
                    state_n    = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: if (tick) begin
                tick_cnt_n = tick_cnt + 1'b1;
                if (tick_cnt == MID_BIT) begin
                    tick_cnt_n = '0;
                    bit_cnt_n  = bit_cnt + 1'b1;
                    shreg_n    = {rx_s, shreg[DATA_BITS-1:1]};
                    state_n    = (bit_cnt == LAST_BIT) ? S_STOP : S_DATA;
                end
            end
            // Leaving at mid-stop re-arms for a start bit with no idle gap.
            S_STOP: if (tick) begin
                tick_cnt_n = tick_cnt + 1'b1;
                if (tick_cnt == MID_BIT) begin
                    tick_cnt_n = '0;
                    out_n      = rx_s ? shreg : Parallel_Out;
                    dv_n       = rx_s;
                    fe_n       = !rx_s;
                    state_n    = rx_s ? S_IDLE : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: if (rx_s) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
endmodule
